// File: rtl/tea_block_feeder.sv
// -----------------------------------------------------------------------------
// tea_block_feeder
//
// Framing stage in front of the pipelined TEA core. It packs pairs of 32-bit
// plaintext words into one 64-bit block {y,z}, optionally XORs the block with
// the CBC chain, starts the core, captures the ciphertext and offers it on a
// valid/ready output port. One block is in flight at a time.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   mode_cbc     1 = CBC chaining, 0 = ECB; sampled with the second word
//   iv           initialisation vector
//   iv_load      load iv into the chain register (IDLE only)
//   in_word      plaintext word: first = y (63:32), second = z (31:0)
//   in_valid     in_word valid
//   in_ready     block can accept in_word
//   core_data    block presented to the core (registered)
//   core_start   one-cycle start pulse to the core ready input
//   core_done    core done
//   core_result  core ciphertext
//   out_block    ciphertext (registered, stable while out_valid)
//   out_valid    out_block valid
//   out_ready    downstream accepts out_block
//   busy         high whenever a block is being assembled or processed
//   timeout_err  sticky: the core did not finish within TIMEOUT_CYCLES
//   block_count  ciphertext blocks delivered (wraps)
//
// All handshake flags are registered and decoded from the next state, so
// every output is 0 during reset and in_ready rises one cycle after release.
// TIMEOUT_CYCLES must exceed the core latency (34 cycles for 32 rounds).
// -----------------------------------------------------------------------------
module tea_block_feeder #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_cbc,
  input  logic [63:0]      iv,
  input  logic             iv_load,
  input  logic [31:0]      in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      core_data,
  output logic             core_start,
  input  logic             core_done,
  input  logic [63:0]      core_result,
  output logic [63:0]      out_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] block_count
);

  // The counter only has to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALF,
    S_START,
    S_ARM,
    S_WAIT,
    S_OUT
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   hi_word;
  logic [63:0]   chain;
  logic [TW-1:0] to_cnt;
  logic          word_acc;
  logic          to_expired;

  assign word_acc   = in_valid & in_ready;
  assign to_expired = (to_cnt == TO_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      S_IDLE:  if (word_acc) state_nx = S_HALF;
      S_HALF:  if (word_acc) state_nx = S_START;
      S_START: state_nx = S_ARM;
      // core_done may still be high from the previous block here; it is
      // deliberately not looked at until WAIT.
      S_ARM:   state_nx = S_WAIT;
      S_WAIT: begin
        if (core_done)       state_nx = S_OUT;
        else if (to_expired) state_nx = S_IDLE;
      end
      S_OUT:   if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered handshake flags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      core_start <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      in_ready   <= (state_nx == S_IDLE) || (state_nx == S_HALF);
      core_start <= (state_nx == S_START);
      out_valid  <= (state_nx == S_OUT);
      busy       <= (state_nx != S_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: the data registers are reset as well; they are few and a reset
  // mid-operation must leave no trace of the discarded block on the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_word     <= '0;
      chain       <= '0;
      core_data   <= '0;
      out_block   <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
      block_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (word_acc) hi_word <= in_word;
          if (iv_load)  chain   <= iv;
        end
        S_HALF: begin
          if (word_acc) begin
            core_data <= mode_cbc ? ({hi_word, in_word} ^ chain)
                                  : {hi_word, in_word};
          end
        end
        S_ARM: begin
          to_cnt <= '0;
        end
        S_WAIT: begin
          to_cnt <= to_cnt + TW'(1);
          if (core_done) begin
            // The chain follows the ciphertext in both modes, so switching
            // to CBC later continues from the last delivered block.
            out_block <= core_result;
            chain     <= core_result;
          end else if (to_expired) begin
            timeout_err <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) block_count <= block_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
